// File: rtl/lifo_stack.sv
// lifo_stack: parameterised LIFO with an internally owned stack pointer.
// The block supports a peekable top, simultaneous push/pop (replace-top),
// a synchronous flush, and sticky overflow/underflow flags.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   push/pop   write / read requests
//   clear      synchronous flush; count returns to 0 and data_out holds
//   err_clr    clears the sticky error flags; a same-cycle error event wins
//   data_in    word to push
//   data_out   registered last popped word
//   pop_valid  one-cycle pulse when data_out was updated
//   top        combinational peek of mem[count-1]; 0 when empty
//   count      number of stored entries, 0..DEPTH
//   full/empty decoded from registered count
//   overflow   sticky: a push was refused while full
//   underflow  sticky: a pop was refused while empty
module lifo_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             ovf_evt;
  logic             unf_evt;

  logic             is_empty;
  logic             is_full;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;

  // Status decode from registered count only.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  // top_idx wraps when empty; every user of it is gated by !is_empty.
  assign top_idx  = AW'(count_q - CNT_W'(1));
  // push_idx truncates when full; it is only used when not full.
  assign push_idx = AW'(count_q);

  // Next-state and memory-write decode in priority order.
  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = push_idx;
    mem_wdata   = data_in;
    ovf_evt     = 1'b0;
    unf_evt     = 1'b0;

    if (clear) begin
      count_d = '0;
    end else if (push && pop) begin
      if (!is_empty) begin
        // Replace-top: return the old top and overwrite it in one cycle.
        data_out_d  = mem_q[top_idx];
        pop_valid_d = 1'b1;
        mem_we      = 1'b1;
        mem_waddr   = top_idx;
      end else begin
        // The pop half has nothing to take, so only the push proceeds.
        mem_we    = 1'b1;
        mem_waddr = '0;
        count_d   = CNT_W'(1);
        unf_evt   = 1'b1;
      end
    end else if (push) begin
      if (!is_full) begin
        mem_we  = 1'b1;
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_evt = 1'b1;
      end
    end else if (pop) begin
      if (!is_empty) begin
        data_out_d  = mem_q[top_idx];
        pop_valid_d = 1'b1;
        count_d     = count_q - CNT_W'(1);
      end else begin
        unf_evt = 1'b1;
      end
    end

    // Sticky flags: err_clr clears them, but a same-cycle event sets them.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_evt) overflow_d  = 1'b1;
    if (unf_evt) underflow_d = 1'b1;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= '0;
      data_out_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out  = data_out_q;
  assign pop_valid = pop_valid_q;
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign top       = is_empty ? '0 : mem_q[top_idx];

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: a queue-based reference model checks instance A
// (WIDTH=8, DEPTH=4) on every cycle with directed and random traffic.
// Instance B (WIDTH=16, DEPTH=3) receives directed checks for a
// non-power-of-two depth and for a reset asserted mid-stream.
module tb_lifo_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8-bit data, 4 entries.
  logic       a_rst, a_push, a_pop, a_clear, a_err_clr;
  logic [7:0] a_din, a_dout, a_top;
  logic       a_pv, a_full, a_empty, a_ovf, a_unf;
  logic [2:0] a_count;

  // Instance B: 16-bit data, 3 entries.
  logic        b_rst, b_push, b_pop, b_clear, b_err_clr;
  logic [15:0] b_din, b_dout, b_top;
  logic        b_pv, b_full, b_empty, b_ovf, b_unf;
  logic [1:0]  b_count;

  lifo_stack #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .rst(a_rst), .push(a_push), .pop(a_pop), .clear(a_clear),
    .err_clr(a_err_clr), .data_in(a_din), .data_out(a_dout),
    .pop_valid(a_pv), .top(a_top), .count(a_count), .full(a_full),
    .empty(a_empty), .overflow(a_ovf), .underflow(a_unf)
  );

  lifo_stack #(.WIDTH(16), .DEPTH(3)) u_b (
    .clk(clk), .rst(b_rst), .push(b_push), .pop(b_pop), .clear(b_clear),
    .err_clr(b_err_clr), .data_in(b_din), .data_out(b_dout),
    .pop_valid(b_pv), .top(b_top), .count(b_count), .full(b_full),
    .empty(b_empty), .overflow(b_ovf), .underflow(b_unf)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: the stack is a queue whose back is the top.
  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_pv   = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_unf  = 1'b0;
  bit         mdl_en = 1'b0;

  task automatic model_step();
    bit oe, ue;
    oe = 1'b0;
    ue = 1'b0;
    if (!a_rst) begin
      mq.delete();
      m_dout = 8'h00;
      m_pv   = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_pv = 1'b0;
      if (a_clear) begin
        mq.delete();
      end else if (a_push && a_pop) begin
        if (mq.size() > 0) begin
          m_dout = mq[$];
          mq[mq.size()-1] = a_din;
          m_pv = 1'b1;
        end else begin
          mq.push_back(a_din);
          ue = 1'b1;
        end
      end else if (a_push) begin
        if (mq.size() < 4) mq.push_back(a_din);
        else oe = 1'b1;
      end else if (a_pop) begin
        if (mq.size() > 0) begin
          m_dout = mq.pop_back();
          m_pv = 1'b1;
        end else begin
          ue = 1'b1;
        end
      end
      if (a_err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (oe) m_ovf = 1'b1;
      if (ue) m_unf = 1'b1;
    end
  endtask

  // Compare instance A against the model away from the active edge.
  always @(negedge clk) begin
    if (mdl_en) begin
      chk("count",     32'(a_count), 32'(mq.size()));
      chk("empty",     32'(a_empty), 32'(mq.size() == 0));
      chk("full",      32'(a_full),  32'(mq.size() == 4));
      chk("top",       32'(a_top),   (mq.size() > 0) ? 32'(mq[$]) : 32'd0);
      chk("data_out",  32'(a_dout),  32'(m_dout));
      chk("pop_valid", 32'(a_pv),    32'(m_pv));
      chk("overflow",  32'(a_ovf),   32'(m_ovf));
      chk("underflow", 32'(a_unf),   32'(m_unf));
    end
  end

  task automatic a_cyc();
    @(posedge clk);
    model_step();
    mdl_en = 1'b1;
    #1;
  endtask

  task automatic a_drv(input bit pu, input bit po, input bit cl, input bit ec, input logic [7:0] d);
    a_rst = 1'b1; a_push = pu; a_pop = po; a_clear = cl; a_err_clr = ec; a_din = d;
    a_cyc();
  endtask

  task automatic b_drv(input bit rs, input bit pu, input bit po, input logic [15:0] d);
    b_rst = rs; b_push = pu; b_pop = po; b_clear = 1'b0; b_err_clr = 1'b0; b_din = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_pop [4];

  initial begin
    exp_pop[0] = 8'h44; exp_pop[1] = 8'h33; exp_pop[2] = 8'h22; exp_pop[3] = 8'h11;
    a_rst = 1'b0; a_push = 1'b1; a_pop = 1'b0; a_clear = 1'b0; a_err_clr = 1'b0; a_din = 8'hAA;
    b_rst = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_clear = 1'b0; b_err_clr = 1'b0; b_din = 16'h0;
    #2;

    // Reset held for two cycles while a push is requested.
    a_cyc();
    a_cyc();
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_top",   32'(a_top),   32'd0);
    chk("rst_dout",  32'(a_dout),  32'd0);
    chk("rst_flags", 32'({a_ovf, a_unf}), 32'd0);

    // Fill the stack, then overflow it.
    a_drv(1, 0, 0, 0, 8'h11);
    a_drv(1, 0, 0, 0, 8'h22);
    a_drv(1, 0, 0, 0, 8'h33);
    a_drv(1, 0, 0, 0, 8'h44);
    a_drv(1, 0, 0, 0, 8'h55);
    chk("fill_full",  32'(a_full),  32'd1);
    chk("fill_count", 32'(a_count), 32'd4);
    chk("fill_top",   32'(a_top),   32'h44);
    chk("fill_ovf",   32'(a_ovf),   32'd1);
    a_drv(0, 0, 0, 1, 8'h00);
    chk("errclr_ovf", 32'(a_ovf), 32'd0);

    // Drain the stack, then underflow it.
    for (int i = 0; i < 4; i++) begin
      a_drv(0, 1, 0, 0, 8'h00);
      chk("drain_dout", 32'(a_dout), 32'(exp_pop[i]));
      chk("drain_pv",   32'(a_pv),   32'd1);
    end
    a_drv(0, 1, 0, 0, 8'h00);
    chk("unf_pv",    32'(a_pv),    32'd0);
    chk("unf_dout",  32'(a_dout),  32'h11);
    chk("unf_flag",  32'(a_unf),   32'd1);
    chk("unf_empty", 32'(a_empty), 32'd1);

    // Replace-top, first when partly full and then when full.
    a_drv(0, 0, 0, 1, 8'h00);
    a_drv(1, 0, 0, 0, 8'h11);
    a_drv(1, 0, 0, 0, 8'h22);
    a_drv(1, 1, 0, 0, 8'h99);
    chk("rep_dout",  32'(a_dout),  32'h22);
    chk("rep_pv",    32'(a_pv),    32'd1);
    chk("rep_count", 32'(a_count), 32'd2);
    chk("rep_top",   32'(a_top),   32'h99);
    a_drv(1, 0, 0, 0, 8'h33);
    a_drv(1, 0, 0, 0, 8'h44);
    a_drv(1, 1, 0, 0, 8'hAB);
    chk("repf_dout",  32'(a_dout),  32'h44);
    chk("repf_count", 32'(a_count), 32'd4);
    chk("repf_top",   32'(a_top),   32'hAB);
    chk("repf_ovf",   32'(a_ovf),   32'd0);

    // Push+pop on an empty stack, then a clear that carries a push.
    a_drv(0, 0, 1, 0, 8'h00);
    a_drv(1, 1, 0, 0, 8'h5A);
    chk("pp_empty_count", 32'(a_count), 32'd1);
    chk("pp_empty_top",   32'(a_top),   32'h5A);
    chk("pp_empty_unf",   32'(a_unf),   32'd1);
    chk("pp_empty_pv",    32'(a_pv),    32'd0);
    a_drv(1, 0, 1, 0, 8'h77);
    chk("clr_count", 32'(a_count), 32'd0);
    chk("clr_flags", 32'({a_ovf, a_unf}), 32'b01);

    // Random traffic checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      a_rst     = ($urandom_range(63) != 0);
      a_push    = 1'($urandom_range(1));
      a_pop     = 1'($urandom_range(1));
      a_clear   = ($urandom_range(15) == 0);
      a_err_clr = ($urandom_range(7) == 0);
      a_din     = 8'($urandom);
      a_cyc();
    end
    a_drv(0, 0, 0, 0, 8'h00);

    // Instance B: non-power-of-two depth and a mid-stream reset.
    b_drv(0, 1, 0, 16'hAAAA);
    b_drv(0, 1, 0, 16'hAAAA);
    b_drv(1, 1, 0, 16'h1234);
    b_drv(1, 1, 0, 16'hBEEF);
    b_drv(1, 1, 0, 16'h0F0F);
    chk("b_full",  32'(b_full),  32'd1);
    chk("b_count", 32'(b_count), 32'd3);
    chk("b_top",   32'(b_top),   32'h0F0F);
    chk("b_empty", 32'(b_empty), 32'd0);
    b_drv(1, 1, 0, 16'hDEAD);
    chk("b_ovf",       32'(b_ovf),   32'd1);
    chk("b_ovf_count", 32'(b_count), 32'd3);
    b_drv(1, 0, 1, 16'h0000);
    chk("b_pop_dout",  32'(b_dout),  32'h0F0F);
    chk("b_pop_pv",    32'(b_pv),    32'd1);
    chk("b_pop_count", 32'(b_count), 32'd2);
    b_drv(1, 1, 0, 16'hCAFE);
    chk("b_top2", 32'(b_top), 32'hCAFE);
    b_drv(0, 1, 0, 16'h5555);
    chk("b_rst_count", 32'(b_count), 32'd0);
    chk("b_rst_empty", 32'(b_empty), 32'd1);
    chk("b_rst_full",  32'(b_full),  32'd0);
    chk("b_rst_top",   32'(b_top),   32'd0);
    chk("b_rst_dout",  32'(b_dout),  32'd0);
    chk("b_rst_pv",    32'(b_pv),    32'd0);
    chk("b_rst_flags", 32'({b_ovf, b_unf}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parameterised LIFO stack with an internally managed stack pointer, occupancy count, peekable top-of-stack, simultaneous push/pop (replace-top), synchronous flush and sticky overflow/underflow error flags. It is the next-generation storage element for the StackArch datapath: the pointer is owned by the block instead of being driven externally, and full/empty are exact for any DEPTH, not only powers of two. Operand-stack and return-stack instances in the core are built from this block.

## Interface

Parameters:

- `WIDTH`, 8: data word width in bits (>= 1).
- `DEPTH`, 4: number of storage entries (>= 2, any integer).
- `CNT_W`, `$clog2(DEPTH+1)`: count width. Derived; not overridden.

Ports:

- `clk`  in  1  rising-edge clock; only clock.
- `rst`  in  1  synchronous, active-low reset (asserted when 0, sampled on rising `clk`).
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `clear`  in  1  synchronous flush.
- `err_clr`  in  1  clears sticky error flags.
- `data_in`  in  WIDTH  word to push.
- `data_out`  out  WIDTH  registered last popped word.
- `pop_valid`  out  1  one-cycle pulse; `data_out` updated this cycle.
- `top`  out  WIDTH  combinational peek of current top entry; 0 when empty.
- `count`  out  CNT_W  number of stored entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: push refused while full.
- `underflow`  out  1  sticky: pop refused while empty.

## Operation

- Storage `mem[0..DEPTH-1]`, not reset. Top entry is `mem[count-1]`; a push writes `mem[count]`.
- Per-cycle priority, evaluated on registered `count`:
  1. `rst`==0: `count`=0, `data_out`=0, `pop_valid`=0, `overflow`=0, `underflow`=0. All other inputs ignored.
  2. `clear`=1: `count`=0; `data_out` holds; `pop_valid`=0; push/pop ignored and do not set error flags.
  3. push=1, pop=1, not empty: replace. `data_out`<=`mem[count-1]`, `mem[count-1]`<=`data_in`, `pop_valid`=1, `count` unchanged. Permitted when full; no overflow.
  4. push=1, pop=1, empty: push only. `mem[0]`<=`data_in`, `count`=1, `pop_valid`=0, `underflow` set.
  5. push only, not full: `mem[count]`<=`data_in`, `count`+1.
  6. push only, full: ignored, storage and `count` unchanged, `overflow` set.
  7. pop only, not empty: `data_out`<=`mem[count-1]`, `count`-1, `pop_valid`=1.
  8. pop only, empty: ignored, `data_out` holds, `pop_valid`=0, `underflow` set.
- `err_clr`=1 clears both flags unless an error event occurs in the same cycle; a same-cycle error event wins and the flag ends at 1. `clear` and `err_clr` are independent.
- `count` never wraps: it never exceeds DEPTH and never goes below 0.
- `full` and `empty` are decoded from registered `count` and are glitch-free relative to `clk`.

## Timing

- Reset values: `data_out`=0, `pop_valid`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, `top`=0.
- Pop latency: 1 cycle. A pop accepted at edge N produces `data_out` and `pop_valid`=1 after edge N. `pop_valid` is high for exactly one cycle per accepted pop.
- Push latency: the word is visible on `top` and in `count` after the accepting edge. Push followed immediately by pop returns that word.
- Back-to-back push or pop on every cycle is supported; no stall.
- `top` is combinational from `mem` and `count` only. There is no combinational path from `push`, `pop` or `data_in` to any output.
- A reset asserted mid-stream takes effect at the next rising edge and discards all contents logically.

## Test plan

- Reset: hold `rst`=0 for 2 cycles with `push`=1 and `data_in`=0xAA, then release. Required: `count`=0, `empty`=1, `top`=0, `data_out`=0, both flags 0.
- Fill and overflow (DEPTH=4): push 0x11, 0x22, 0x33, 0x44, then 0x55. Required: `full`=1, `count`=4, `top`=0x44, `overflow`=1. Then pulse `err_clr`: `overflow`=0.
- Drain and underflow: pop 5 times back-to-back. Required: `data_out`=0x44, 0x33, 0x22, 0x11 on successive cycles, each with `pop_valid`=1. The fifth pop gives `pop_valid`=0, `data_out` holding 0x11, `underflow`=1, `empty`=1.
- Replace: with 0x11 and 0x22 stacked, drive push=1, pop=1 and `data_in`=0x99. Required: `data_out`=0x22, `pop_valid`=1, `count`=2, `top`=0x99. Repeat while full: no overflow.
- Edge cases: on an empty stack drive push=1, pop=1 and `data_in`=0x5A. Required: `count`=1, `top`=0x5A, `underflow`=1, `pop_valid`=0. Then drive `clear`=1 with push=1. Required: `count`=0, no error flag change.
- Non-power-of-two and mid-run reset: with DEPTH=3 and WIDTH=16, push 3 words, then `full`=1. Assert `rst`=0 for one cycle mid-stream. Required: all outputs return to their reset values on the next edge.
